// File: rtl/mesh_out_port_arbiter_if.sv
// Handshake bundle between one output-port arbiter, the N_REQ input FIFO
// heads it watches and the output FIFO it feeds.
// master: the arbiter. slave: the FIFO side.
interface mesh_out_port_arbiter_if #(
    parameter int N_REQ   = 4,
    parameter int pckg_sz = 20
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]         pndng;
    logic [N_REQ*pckg_sz-1:0] data_in;
    logic [N_REQ-1:0]         pop;
    logic                     full;
    logic                     push;
    logic [pckg_sz-1:0]       data_out;
    logic [GW-1:0]            grant_id;
    logic                     busy;
    logic                     stall_err;

    modport master (
        input  pndng, data_in, full,
        output pop, push, data_out, grant_id, busy, stall_err
    );

    modport slave (
        output pndng, data_in, full,
        input  pop, push, data_out, grant_id, busy, stall_err
    );
endinterface

// File: rtl/mesh_out_port_arbiter.sv
// Output-port scheduler of one mesh router.
// Heads routed to OUT_DIR by dimension-order routing compete round-robin;
// the winner is held, then pushed to the output FIFO while its input FIFO
// is popped in the same cycle (IDLE -> ARB -> XFER, 3 cycles minimum).
// Optional stall watchdog: define MESH_ARB_STALL_WD_EN.
module mesh_out_port_arbiter #(
    parameter int N_REQ     = 4,
    parameter int pckg_sz   = 20,
    parameter int ID_ROW    = 1,
    parameter int ID_COL    = 1,
    parameter int OUT_DIR   = 0,
    parameter int STALL_MAX = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    mesh_out_port_arbiter_if.master port
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] DIR_N = 3'd0;
    localparam logic [2:0] DIR_S = 3'd1;
    localparam logic [2:0] DIR_E = 3'd2;
    localparam logic [2:0] DIR_W = 3'd3;
    localparam logic [2:0] DIR_L = 3'd4;

    typedef enum logic [1:0] {IDLE = 2'd0, ARB = 2'd1, XFER = 2'd2} state_t;

    state_t             state_r, state_nxt_s;
    logic [GW-1:0]      rr_ptr_r, grant_id_r, win_idx_s;
    logic [pckg_sz-1:0] held_r;
    logic [N_REQ-1:0]   req_s, pop_s;
    logic               win_vld_s, push_s, busy_s;

    // Routing fields: hdr[8:5] dest row, hdr[4:1] dest col, hdr[0] mode (1 = row-first).
    function automatic logic [2:0] route_dir(input logic [8:0] hdr);
        logic [2:0] row_d, col_d;
        if (hdr[8:5] < 4'(ID_ROW)) begin
            row_d = DIR_N;
        end else if (hdr[8:5] > 4'(ID_ROW)) begin
            row_d = DIR_S;
        end else begin
            row_d = DIR_L;
        end
        if (hdr[4:1] < 4'(ID_COL)) begin
            col_d = DIR_W;
        end else if (hdr[4:1] > 4'(ID_COL)) begin
            col_d = DIR_E;
        end else begin
            col_d = DIR_L;
        end
        if (hdr[0]) begin
            route_dir = (row_d != DIR_L) ? row_d : col_d;
        end else begin
            route_dir = (col_d != DIR_L) ? col_d : row_d;
        end
    endfunction

    // Per-requester request: pending head whose route lands on this port.
    always_comb begin
        req_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_s[i] = port.pndng[i] &&
                       (route_dir(port.data_in[i*pckg_sz + pckg_sz - 9 -: 9]) == 3'(OUT_DIR));
        end
    end

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_vld_s = 1'b0;
        win_idx_s = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_r) + k) % N_REQ;
            if (!win_vld_s && req_s[idx]) begin
                win_vld_s = 1'b1;
                win_idx_s = GW'(idx);
            end else begin
                win_vld_s = win_vld_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = win_vld_s ? ARB : IDLE;
            ARB:     state_nxt_s = XFER;
            XFER:    state_nxt_s = port.full ? XFER : IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Strobes: push and the winner's pop fire together in XFER when the output FIFO has room.
    always_comb begin
        busy_s = (state_r != IDLE);
        push_s = (state_r == XFER) && !port.full;
        pop_s  = '0;
        if (push_s) begin
            pop_s = N_REQ'(1) << grant_id_r;
        end else begin
            pop_s = '0;
        end
    end

    // Grant capture and packet holding register, loaded when a winner is picked in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id_r <= '0;
            held_r     <= '0;
        end else if (state_r == IDLE && win_vld_s) begin
            grant_id_r <= win_idx_s;
            held_r     <= port.data_in[int'(win_idx_s)*pckg_sz +: pckg_sz];
        end else begin
            grant_id_r <= grant_id_r;
            held_r     <= held_r;
        end
    end

    // Round-robin pointer moves past the requester just served.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r <= '0;
        end else if (push_s) begin
            rr_ptr_r <= (grant_id_r == GW'(N_REQ - 1)) ? '0 : grant_id_r + GW'(1);
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    assign port.push     = push_s;
    assign port.pop      = pop_s;
    assign port.busy     = busy_s;
    assign port.data_out = held_r;
    assign port.grant_id = grant_id_r;

`ifdef MESH_ARB_STALL_WD_EN
    localparam int SW = $clog2(STALL_MAX + 1);

    logic [SW-1:0] stall_cnt_r;
    logic          stall_err_r;

    // Watchdog: count blocked XFER cycles, latch a sticky error at STALL_MAX.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
            stall_err_r <= 1'b0;
        end else if (push_s) begin
            stall_cnt_r <= '0;
            stall_err_r <= stall_err_r;
        end else if (state_r == XFER && port.full) begin
            if (stall_cnt_r != SW'(STALL_MAX)) begin
                stall_cnt_r <= stall_cnt_r + SW'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (stall_cnt_r >= SW'(STALL_MAX - 1)) begin
                stall_err_r <= 1'b1;
            end else begin
                stall_err_r <= stall_err_r;
            end
        end else begin
            stall_cnt_r <= stall_cnt_r;
            stall_err_r <= stall_err_r;
        end
    end

    assign port.stall_err = stall_err_r;
`else
    // Without the watchdog the flag folds to constant 0 (STALL_MAX is always positive).
    assign port.stall_err = (STALL_MAX < 0) ? 1'b1 : 1'b0;
`endif
endmodule

// File: tb/tb_mesh_out_port_arbiter.sv
// Bench for mesh_out_port_arbiter (router 1,1, port E). Input FIFOs are
// bench queues; a transaction-level model decides routing, round-robin
// order, latency and the watchdog, and every cycle is compared.
module tb_mesh_out_port_arbiter;
    localparam int N    = 4;
    localparam int W    = 20;
    localparam int OUT  = 2;
    localparam int SMAX = 64;
`ifdef MESH_ARB_STALL_WD_EN
    localparam int WD_ON = 1;
`else
    localparam int WD_ON = 0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mesh_out_port_arbiter_if #(.N_REQ(N), .pckg_sz(W)) bus ();

    mesh_out_port_arbiter #(
        .N_REQ(N), .pckg_sz(W), .ID_ROW(1), .ID_COL(1),
        .OUT_DIR(OUT), .STALL_MAX(SMAX)
    ) dut (
        .clk(clk), .reset(reset), .port(bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [W-1:0] fq[N][$];

    // reference model state
    bit           m_busy;
    int           m_win, m_gid, m_rr, m_gcyc, m_stall;
    bit           m_err;
    logic [W-1:0] m_pkt;
    int           cyc;
    int           push_cnt;
    int           gorder[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Dimension-order routing: 0=N 1=S 2=E 3=W 4=local, router at (1,1).
    function automatic int dir_of(input logic [W-1:0] p);
        int r, c, vert, horz;
        r    = int'(p[11:8]);
        c    = int'(p[7:4]);
        vert = (r < 1) ? 0 : ((r > 1) ? 1 : -1);
        horz = (c < 1) ? 3 : ((c > 1) ? 2 : -1);
        if (p[3]) return (vert >= 0) ? vert : ((horz >= 0) ? horz : 4);
        return (horz >= 0) ? horz : ((vert >= 0) ? vert : 4);
    endfunction

    function automatic logic [W-1:0] mk(input int r, input int c, input bit mode);
        logic [7:0] nj;
        logic [2:0] pl;
        nj = 8'($urandom);
        pl = 3'($urandom);
        return {nj, 4'(r), 4'(c), mode, pl};
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_win = 0; m_gid = 0; m_rr = 0;
        m_gcyc = 0; m_stall = 0; m_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_push",  32'(bus.push), 32'd0);
        chk("rst_pop",   32'(bus.pop), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_gid",   32'(bus.grant_id), 32'd0);
        chk("rst_data",  32'(bus.data_out), 32'd0);
        chk("rst_stall", 32'(bus.stall_err), 32'd0);
        model_reset();
    endtask

    // One clock cycle: drive FIFO heads and full, compare, advance the model over the coming edge.
    task automatic step(input bit f);
        bit xfer, exp_push;
        int idx;
        @(negedge clk);
        reset = 1'b0;
        cyc++;
        bus.full = f;
        for (int i = 0; i < N; i++) begin
            bus.pndng[i] = (fq[i].size() > 0);
            bus.data_in[i*W +: W] = (fq[i].size() > 0) ? fq[i][0] : W'($urandom);
        end
        #1;
        xfer     = m_busy && (cyc >= m_gcyc + 2);
        exp_push = xfer && !f;
        chk("push",  32'(bus.push), 32'(exp_push));
        chk("pop",   32'(bus.pop), exp_push ? (32'd1 << m_win) : 32'd0);
        chk("busy",  32'(bus.busy), 32'(m_busy));
        chk("gid",   32'(bus.grant_id), 32'(m_gid));
        chk("stall", 32'(bus.stall_err), (WD_ON != 0) ? 32'(m_err) : 32'd0);
        if (exp_push) chk("data", 32'(bus.data_out), 32'(m_pkt));

        if (xfer && f) begin
            m_stall++;
            if (m_stall >= SMAX) m_err = 1'b1;
        end
        if (exp_push) begin
            if (fq[m_win].size() > 0) void'(fq[m_win].pop_front());
            gorder.push_back(m_win);
            push_cnt++;
            m_rr    = (m_win + 1) % N;
            m_busy  = 1'b0;
            m_stall = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_rr + k) % N;
                if (!m_busy && fq[idx].size() > 0 && dir_of(fq[idx][0]) == OUT) begin
                    m_busy = 1'b1;
                    m_win  = idx;
                    m_gid  = idx;
                    m_pkt  = fq[idx][0];
                    m_gcyc = cyc;
                end
            end
        end
    endtask

    initial begin
        int base, q, r, c;
        bus.full    = 1'b0;
        bus.pndng   = '0;
        bus.data_in = '0;
        cyc = 0; push_cnt = 0;
        model_reset();
        do_reset();

        // single route, column-first to E: push 2 cycles after request, grant 2
        fq[2].push_back(mk(1, 2, 1'b0));
        repeat (4) step(1'b0);
        chk("single_cnt", 32'(push_cnt), 32'd1);
        chk("single_gid", 32'(bus.grant_id), 32'd2);

        // misrouted: r=0,c=2 row-first goes N, never served here
        fq[1].push_back(mk(0, 2, 1'b1));
        repeat (20) step(1'b0);
        chk("misroute_cnt", 32'(push_cnt), 32'd1);
        fq[1].delete();

        // same coordinates column-first goes E and is served
        fq[0].push_back(mk(0, 2, 1'b0));
        repeat (4) step(1'b0);
        chk("mode0_cnt", 32'(push_cnt), 32'd2);

        // round-robin: two E packets per requester, 8 pushes in 24 cycles
        do_reset();
        gorder.delete();
        base = push_cnt;
        for (int i = 0; i < N; i++) begin
            fq[i].push_back(mk(1, 2, 1'($urandom)));
            fq[i].push_back(mk(2, 3, 1'b0));
        end
        repeat (24) step(1'b0);
        chk("rr_cnt", 32'(push_cnt - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk("rr_order", (i < gorder.size()) ? 32'(gorder[i]) : 32'hFFFF, 32'(i % N));
        end

        // backpressure: 10 blocked XFER cycles, then exactly one push
        base = push_cnt;
        fq[3].push_back(mk(1, 2, 1'b1));
        repeat (2) step(1'b0);
        repeat (10) step(1'b1);
        chk("bp_hold", 32'(push_cnt - base), 32'd0);
        repeat (5) step(1'b0);
        chk("bp_once", 32'(push_cnt - base), 32'd1);

        // reset while blocked in XFER: nothing popped, packet re-served afterwards
        base = push_cnt;
        fq[0].push_back(mk(2, 2, 1'b0));
        repeat (2) step(1'b0);
        repeat (3) step(1'b1);
        do_reset();
        repeat (5) step(1'b0);
        chk("rst_reserve", 32'(push_cnt - base), 32'd1);

        // watchdog: STALL_MAX blocked cycles sets a sticky flag
        fq[1].push_back(mk(1, 3, 1'b1));
        repeat (2) step(1'b0);
        repeat (SMAX) step(1'b1);
        repeat (4) step(1'b0);
        chk("wd_sticky", 32'(bus.stall_err), 32'(WD_ON));

        // randomized traffic
        do_reset();
        repeat (600) begin
            if ($urandom_range(0, 9) < 4) begin
                q = $urandom_range(0, N - 1);
                r = $urandom_range(0, 2);
                c = $urandom_range(0, 2);
                if (fq[q].size() < 4) fq[q].push_back(mk(r, c, 1'($urandom)));
            end
            step($urandom_range(0, 3) == 0);
            // drop heads routed elsewhere now and then so queues keep moving
            if ($urandom_range(0, 15) == 0) begin
                q = $urandom_range(0, N - 1);
                if (fq[q].size() > 0 && dir_of(fq[q][0]) != OUT && !(m_busy && m_win == q))
                    void'(fq[q].pop_front());
            end
        end
        repeat (10) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
